// File: rtl/dual_issue_hold.sv
// dual_issue_hold: buffers decoded even/odd pairs and issues them together once both pipes are hazard-free.
// Optional feature macro ISSUE_STALL_CNT_EN enables the saturating hold-cycle counter on stall_cnt.
module dual_issue_hold #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [0:39]      dec_even,
  input  logic [0:39]      dec_odd,
  input  logic [0:23]      dec_even_src,
  input  logic [0:15]      dec_odd_src,
  output logic [0:7]       ra_even_addr,
  output logic [0:7]       rb_even_addr,
  output logic [0:7]       rc_even_addr,
  output logic [0:7]       ra_odd_addr,
  output logic [0:7]       rb_odd_addr,
  input  logic             stall_even_raw,
  input  logic             stall_odd_raw,
  input  logic             branch_taken,
  output logic [0:39]      iss_even,
  output logic [0:39]      iss_odd,
  output logic             iss_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 120;
  localparam logic [0:7] NO_SRC = 8'hFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic             accept_en;
  logic [0:EW-1]    entry [DEPTH];
  logic [0:EW-1]    head;
  logic [0:EW-1]    push_data;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             head_valid;
  logic             any_stall;
  logic             fire;
  logic             push;
  logic             hold_cycle;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry layout: {even bundle, odd bundle, even sources, odd sources}
  assign push_data  = {dec_even, dec_odd, dec_even_src, dec_odd_src};
  assign head       = entry[rd_ptr];
  assign head_valid = (count != '0);
  assign any_stall  = stall_even_raw | stall_odd_raw;

  // dec_ready depends only on registered state, never on the stall inputs
  assign dec_ready  = !reset && accept_en && (count < CW'(DEPTH));
  assign push       = dec_valid && dec_ready && !branch_taken;
  assign fire       = head_valid && !any_stall && !branch_taken;
  assign hold_cycle = head_valid && any_stall && !branch_taken;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [0:EW-1] data;

      always_ff @(posedge clk) begin
        if (push && (wr_ptr == PTR_W'(gi))) begin
          data <= push_data;
        end
      end

      assign entry[gi] = data;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ra_even_addr = head_valid ? head[80:87]   : NO_SRC;
  assign rb_even_addr = head_valid ? head[88:95]   : NO_SRC;
  assign rc_even_addr = head_valid ? head[96:103]  : NO_SRC;
  assign ra_odd_addr  = head_valid ? head[104:111] : NO_SRC;
  assign rb_odd_addr  = head_valid ? head[112:119] : NO_SRC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (branch_taken) begin
      state_next = FLUSH;
    end else begin
      case (state)
        RUN:     state_next = hold_cycle ? HOLD : RUN;
        HOLD:    state_next = fire ? RUN : (hold_cycle ? HOLD : RUN);
        FLUSH:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    accept_en = 1'b1;
    case (state)
      FLUSH:   accept_en = 1'b0;
      default: accept_en = 1'b1;
    endcase
  end

  // Both halves leave together; anything but a firing head issues a nop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_even  <= '0;
      iss_odd   <= '0;
      iss_valid <= 1'b0;
    end else if (fire) begin
      iss_even  <= head[0:39];
      iss_odd   <= head[40:79];
      iss_valid <= 1'b1;
    end else begin
      iss_even  <= '0;
      iss_odd   <= '0;
      iss_valid <= 1'b0;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (hold_cycle && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_issue_hold.sv
// Randomized and directed bench for dual_issue_hold against a queue-based pair model.
// Honours ISSUE_STALL_CNT_EN when computing the expected stall_cnt.
module tb_dual_issue_hold;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [0:39] e;
    logic [0:39] o;
    logic [0:23] es;
    logic [0:15] os;
  } pair_t;

  logic             clk;
  logic             reset;
  logic             dec_valid;
  logic             dec_ready;
  logic [0:39]      dec_even;
  logic [0:39]      dec_odd;
  logic [0:23]      dec_even_src;
  logic [0:15]      dec_odd_src;
  logic [0:7]       ra_even_addr, rb_even_addr, rc_even_addr;
  logic [0:7]       ra_odd_addr, rb_odd_addr;
  logic             stall_even_raw;
  logic             stall_odd_raw;
  logic             branch_taken;
  logic [0:39]      iss_even;
  logic [0:39]      iss_odd;
  logic             iss_valid;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pair_t            q[$];
  bit               m_flush;
  logic             m_iss_v;
  logic [0:39]      m_iss_e, m_iss_o;
  logic [CNT_W-1:0] m_cnt;

  dual_issue_hold #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_even(dec_even), .dec_odd(dec_odd),
    .dec_even_src(dec_even_src), .dec_odd_src(dec_odd_src),
    .ra_even_addr(ra_even_addr), .rb_even_addr(rb_even_addr), .rc_even_addr(rc_even_addr),
    .ra_odd_addr(ra_odd_addr), .rb_odd_addr(rb_odd_addr),
    .stall_even_raw(stall_even_raw), .stall_odd_raw(stall_odd_raw),
    .branch_taken(branch_taken),
    .iss_even(iss_even), .iss_odd(iss_odd), .iss_valid(iss_valid),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pair_t rand_pair();
    pair_t p;
    p.e  = {$urandom, 8'($urandom)};
    p.o  = {$urandom, 8'($urandom)};
    p.es = 24'($urandom);
    p.os = 16'($urandom);
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_flush = 0;
    m_iss_v = 1'b0;
    m_iss_e = '0;
    m_iss_o = '0;
    m_cnt   = '0;
  endtask

  // One clock of the pair-level rules, using the inputs present at the edge
  task automatic model_edge();
    bit    rdy;
    bit    go;
    pair_t in_p;
    in_p = {dec_even, dec_odd, dec_even_src, dec_odd_src};
    rdy  = (q.size() < DEPTH) && !m_flush;
    if (branch_taken) begin
      q.delete();
      m_iss_v = 1'b0; m_iss_e = '0; m_iss_o = '0;
      m_flush = 1;
    end else begin
`ifdef ISSUE_STALL_CNT_EN
      if (q.size() != 0 && (stall_even_raw || stall_odd_raw) && m_cnt != '1) m_cnt = m_cnt + 1;
`endif
      go = (q.size() != 0) && !stall_even_raw && !stall_odd_raw;
      if (go) begin
        m_iss_v = 1'b1; m_iss_e = q[0].e; m_iss_o = q[0].o;
        void'(q.pop_front());
      end else begin
        m_iss_v = 1'b0; m_iss_e = '0; m_iss_o = '0;
      end
      if (dec_valid && rdy) q.push_back(in_p);
      m_flush = 0;
    end
  endtask

  task automatic drive(input bit v, input pair_t p, input bit se, input bit so, input bit br);
    dec_valid      = v;
    dec_even       = p.e;
    dec_odd        = p.o;
    dec_even_src   = p.es;
    dec_odd_src    = p.os;
    stall_even_raw = se;
    stall_odd_raw  = so;
    branch_taken   = br;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, '0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, '0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%0b want=0", iss_valid); end
    total++; if ({iss_even, iss_odd} !== 80'b0) begin bad++; $display("FAIL reset_iss_nop got=%h want=0", {iss_even, iss_odd}); end
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL reset_dec_ready got=%0b want=0", dec_ready); end
    total++; if (ra_even_addr !== 8'hFF) begin bad++; $display("FAIL reset_addr got=%h want=ff", ra_even_addr); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    reset = 1'b0;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b want=1", dec_ready); end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    pair_t a, b;
    a = rand_pair();
    b = rand_pair();
    drive(1, a, 0, 0, 0); #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%0b want=1", dec_ready); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL b2b_first_edge got=%0b want=0", iss_valid); end
    drive(1, b, 0, 0, 0); #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%0b want=1", dec_ready); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_even !== a.e || iss_odd !== a.o) begin
      bad++; $display("FAIL b2b_pair_a got=%0b/%h/%h want=1/%h/%h", iss_valid, iss_even, iss_odd, a.e, a.o); end
    drive(0, '0, 0, 0, 0);
    tick();
    total++; if (iss_valid !== 1'b1 || iss_even !== b.e || iss_odd !== b.o) begin
      bad++; $display("FAIL b2b_pair_b got=%0b/%h/%h want=1/%h/%h", iss_valid, iss_even, iss_odd, b.e, b.o); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b want=0", iss_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_even_stall();
    pair_t            p;
    logic [CNT_W-1:0] c0, want;
    p = rand_pair();
    p.es[0:7] = 8'h05;
    idle(2);
    c0 = m_cnt;
    drive(1, p, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0, 0); #1;
      total++; if (ra_even_addr !== 8'h05) begin bad++; $display("FAIL estall_ra cyc=%0d got=%h want=05", i, ra_even_addr); end
      tick();
      total++; if (iss_valid !== 1'b0 || iss_even !== 40'b0) begin
        bad++; $display("FAIL estall_hold cyc=%0d got=%0b/%h want=0/0", i, iss_valid, iss_even); end
    end
    drive(0, '0, 0, 0, 0);
    tick();
    total++; if (iss_valid !== 1'b1 || iss_even !== p.e || iss_odd !== p.o) begin
      bad++; $display("FAIL estall_issue got=%0b/%h/%h want=1/%h/%h", iss_valid, iss_even, iss_odd, p.e, p.o); end
`ifdef ISSUE_STALL_CNT_EN
    want = c0 + 3;
`else
    want = '0;
`endif
    total++; if (stall_cnt !== want) begin bad++; $display("FAIL estall_cnt got=%0d want=%0d", stall_cnt, want); end
    $display("test_even_stall done");
  endtask

  task automatic test_odd_stall();
    pair_t p;
    p = rand_pair();
    drive(1, p, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, '0, 0, 1, 0);
      tick();
      total++; if (iss_valid !== 1'b0 || iss_even !== 40'b0 || iss_odd !== 40'b0) begin
        bad++; $display("FAIL ostall_hold cyc=%0d got=%0b/%h/%h want=0/0/0", i, iss_valid, iss_even, iss_odd); end
    end
    drive(0, '0, 0, 0, 0);
    tick();
    total++; if (iss_valid !== 1'b1 || iss_even !== p.e || iss_odd !== p.o) begin
      bad++; $display("FAIL ostall_issue got=%0b/%h/%h want=1/%h/%h", iss_valid, iss_even, iss_odd, p.e, p.o); end
    $display("test_odd_stall done");
  endtask

  task automatic test_fill_full();
    pair_t a, b, c;
    a = rand_pair(); b = rand_pair(); c = rand_pair();
    drive(1, a, 1, 0, 0); tick();
    drive(1, b, 1, 0, 0); tick();
    drive(1, c, 1, 0, 0); #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", dec_ready); end
    tick();
    drive(0, '0, 0, 0, 0); #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL full_release_comb got=%0b want=0", dec_ready); end
    tick();
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%0b want=1", dec_ready); end
    total++; if (iss_valid !== 1'b1 || iss_even !== a.e) begin
      bad++; $display("FAIL full_issue_a got=%0b/%h want=1/%h", iss_valid, iss_even, a.e); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_odd !== b.o) begin
      bad++; $display("FAIL full_issue_b got=%0b/%h want=1/%h", iss_valid, iss_odd, b.o); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_no_dup got=%0b want=0", iss_valid); end
    $display("test_fill_full done");
  endtask

  task automatic test_flush();
    drive(1, rand_pair(), 1, 0, 0); tick();
    drive(1, rand_pair(), 1, 0, 0); tick();
    drive(1, rand_pair(), 0, 0, 1);
    tick();
    total++; if (iss_valid !== 1'b0 || iss_even !== 40'b0) begin
      bad++; $display("FAIL flush_nop got=%0b/%h want=0/0", iss_valid, iss_even); end
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b want=0", dec_ready); end
    total++; if (ra_even_addr !== 8'hFF) begin bad++; $display("FAIL flush_empty got=%h want=ff", ra_even_addr); end
    drive(1, rand_pair(), 0, 0, 0);
    tick();
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_back got=%0b want=1", dec_ready); end
    total++; if (rb_odd_addr !== 8'hFF || iss_valid !== 1'b0) begin
      bad++; $display("FAIL flush_dropped got=%h/%0b want=ff/0", rb_odd_addr, iss_valid); end
    idle(2);
    $display("test_flush done");
  endtask

  task automatic test_random();
    pair_t h;
    bit    rdy;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9, 0) < 7, rand_pair(), $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0);
      #1;
      h   = (q.size() != 0) ? q[0] : {80'b0, 24'hFFFFFF, 16'hFFFF};
      rdy = (q.size() < DEPTH) && !m_flush;
      total++; if (dec_ready !== rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", i, dec_ready, rdy); end
      total++; if ({ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr} !== {h.es, h.os}) begin
        bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", i,
                        {ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr}, {h.es, h.os}); end
      tick();
      total++; if (iss_valid !== m_iss_v || iss_even !== m_iss_e || iss_odd !== m_iss_o) begin
        bad++; $display("FAIL rnd_issue cyc=%0d got=%0b/%h/%h want=%0b/%h/%h", i,
                        iss_valid, iss_even, iss_odd, m_iss_v, m_iss_e, m_iss_o); end
      total++; if (stall_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, m_cnt); end
    end
    idle(4);
    $display("test_random done");
  endtask

  task automatic test_reset_mid_hold();
    pair_t p;
    p = rand_pair();
    p.es[0:7] = 8'h11;
    drive(1, p, 0, 0, 0); tick();
    drive(0, '0, 1, 0, 0); tick();
    tick();
    #2 reset = 1'b1;
    #1;
    total++; if (iss_valid !== 1'b0 || iss_even !== 40'b0) begin
      bad++; $display("FAIL rst_hold_iss got=%0b/%h want=0/0", iss_valid, iss_even); end
    total++; if ({ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr} !== 40'hFFFFFFFFFF) begin
      bad++; $display("FAIL rst_hold_addr got=%h want=ffffffffff",
                      {ra_even_addr, rb_even_addr, rc_even_addr, ra_odd_addr, rb_odd_addr}); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL rst_hold_cnt got=%0d want=0", stall_cnt); end
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL rst_hold_ready got=%0b want=0", dec_ready); end
    model_reset();
    drive(0, '0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    total++; if (iss_valid !== 1'b0 || dec_ready !== 1'b1) begin
      bad++; $display("FAIL rst_hold_after got=%0b/%0b want=0/1", iss_valid, dec_ready); end
    $display("test_reset_mid_hold done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_even_stall();
    test_odd_stall();
    test_fill_full();
    test_flush();
    test_random();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
